// File: rtl/distram_fifo_ctrl.sv
// First-word-fall-through valid/ready FIFO controller driving an external
// distributed RAM (synchronous write port, combinational read port).
module distram_fifo_ctrl #(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 32,
    parameter int AFULL_LVL = 28
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  logic [WIDTH-1:0]           enq_data,
    output logic                       enq_ready,
    output logic                       deq_valid,
    output logic [WIDTH-1:0]           deq_data,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       ovf_err,
    output logic                       ram_wen,
    output logic [$clog2(DEPTH)-1:0]   ram_windex,
    output logic [WIDTH-1:0]           ram_wdata,
    output logic [$clog2(DEPTH)-1:0]   ram_rindex,
    input  logic [WIDTH-1:0]           ram_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          enq_fire;
    logic          deq_fire;

    // Readiness is purely a function of registered occupancy, so a full FIFO
    // refuses an enqueue even in a cycle where the head is being consumed.
    assign enq_ready   = (count != CW'(DEPTH));
    assign deq_valid   = (count != '0);
    assign almost_full = (count >= CW'(AFULL_LVL));

    assign enq_fire = enq_valid & enq_ready;
    assign deq_fire = deq_valid & deq_ready;

    assign ram_wen    = enq_fire & ~flush;
    assign ram_windex = wr_ptr;
    assign ram_wdata  = enq_data;
    assign ram_rindex = rd_ptr;
    assign deq_data   = ram_rdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq_fire)
                    wr_ptr <= wr_ptr + AW'(1);
                if (deq_fire)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({enq_fire, deq_fire})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
            // Sticky until reset; a flush cycle never records an overflow.
            if (enq_valid && !enq_ready && !flush)
                ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_distram_fifo_ctrl.sv
// Testbench for distram_fifo_ctrl: behavioural RAM plus a queue-based
// reference model of FIFO contents, occupancy and overflow flag.
module tb_distram_fifo_ctrl;

    localparam int DEPTH = 32;
    localparam int WIDTH = 32;
    localparam int AFULL = 28;

    logic             CLK;
    logic             RST;
    logic             flush;
    logic             enq_valid;
    logic [WIDTH-1:0] enq_data;
    logic             enq_ready;
    logic             deq_valid;
    logic [WIDTH-1:0] deq_data;
    logic             deq_ready;
    logic [5:0]       count;
    logic             almost_full;
    logic             ovf_err;
    logic             ram_wen;
    logic [4:0]       ram_windex;
    logic [WIDTH-1:0] ram_wdata;
    logic [4:0]       ram_rindex;
    logic [WIDTH-1:0] ram_rdata;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] q[$];
    bit               m_ovf;
    int               m_w;
    int               m_r;
    int               n_cmp;
    int               n_fail;

    distram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_LVL(AFULL)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
        .deq_valid(deq_valid), .deq_data(deq_data), .deq_ready(deq_ready),
        .count(count), .almost_full(almost_full), .ovf_err(ovf_err),
        .ram_wen(ram_wen), .ram_windex(ram_windex), .ram_wdata(ram_wdata),
        .ram_rindex(ram_rindex), .ram_rdata(ram_rdata)
    );

    // Distributed RAM stand-in: write on clock, read combinationally
    always @(posedge CLK) if (ram_wen) mem[ram_windex] <= ram_wdata;
    assign ram_rdata = mem[ram_rindex];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic drive(input bit ev, input logic [WIDTH-1:0] ed, input bit dr,
                         input bit fl, input bit rs);
        enq_valid = ev;
        enq_data  = ed;
        deq_ready = dr;
        flush     = fl;
        RST       = rs;
        #1;
    endtask

    // Advance one clock, updating the model from the inputs held this cycle
    task automatic tick();
        bit ef, df;
        @(posedge CLK);
        ef = enq_valid && (q.size() < DEPTH);
        df = deq_ready && (q.size() > 0);
        if (RST) begin
            q.delete(); m_ovf = 0; m_w = 0; m_r = 0;
        end else if (flush) begin
            q.delete(); m_w = 0; m_r = 0;
        end else begin
            if (enq_valid && !ef) m_ovf = 1;
            if (df) begin void'(q.pop_front()); m_r = (m_r + 1) % DEPTH; end
            if (ef) begin q.push_back(enq_data); m_w = (m_w + 1) % DEPTH; end
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 1); tick(); tick();
        drive(0, 0, 0, 0, 0);
        n_cmp += 5;
        if (count !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        if (enq_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_enq_ready: got %b expected 1", enq_ready); end
        if (deq_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_deq_valid: got %b expected 0", deq_valid); end
        if (ovf_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf_err); end
        if (almost_full !== 1'b0 || ram_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_afull_wen: got %b%b expected 00", almost_full, ram_wen); end
    endtask

    task automatic test_single();
        drive(1, 32'hDEADBEEF, 1, 0, 0);
        n_cmp += 3;
        if (ram_wen !== 1'b1) begin n_fail++; $display("[TB] FAIL single_wen: got %b expected 1", ram_wen); end
        if (ram_windex !== 5'd0) begin n_fail++; $display("[TB] FAIL single_windex: got %0d expected 0", ram_windex); end
        if (deq_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_no_bypass: got %b expected 0", deq_valid); end
        tick();
        drive(0, 0, 1, 0, 0);
        n_cmp += 2;
        if (deq_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_deq_valid: got %b expected 1", deq_valid); end
        if (deq_data !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL single_deq_data: got %h expected deadbeef", deq_data); end
        tick();
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (count !== 6'd0) begin n_fail++; $display("[TB] FAIL single_count: got %0d expected 0", count); end
    endtask

    task automatic test_fill_wrap();
        drive(0, 0, 0, 1, 0); tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, WIDTH'(i), 0, 0, 0);
            n_cmp += 3;
            if (ram_windex !== 5'(i)) begin n_fail++; $display("[TB] FAIL fill_windex: got %0d expected %0d", ram_windex, i); end
            if (enq_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_enq_ready: got %b expected 1 at %0d", enq_ready, i); end
            if (almost_full !== (q.size() >= AFULL)) begin n_fail++; $display("[TB] FAIL fill_afull: got %b expected %b at %0d", almost_full, q.size() >= AFULL, i); end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        n_cmp += 3;
        if (count !== 6'd32) begin n_fail++; $display("[TB] FAIL full_count: got %0d expected 32", count); end
        if (enq_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_enq_ready: got %b expected 0", enq_ready); end
        if (almost_full !== 1'b1) begin n_fail++; $display("[TB] FAIL full_afull: got %b expected 1", almost_full); end
        for (int k = 0; k < 16; k++) begin
            drive(0, 0, 1, 0, 0);
            n_cmp++;
            if (deq_data !== WIDTH'(k)) begin n_fail++; $display("[TB] FAIL drain1_data: got %0d expected %0d", deq_data, k); end
            tick();
        end
        for (int k = 0; k < 16; k++) begin
            drive(1, WIDTH'(32 + k), 0, 0, 0);
            n_cmp++;
            if (ram_windex !== 5'(k) || ram_wen !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_windex: got %0d/%b expected %0d/1", ram_windex, ram_wen, k); end
            tick();
        end
        for (int k = 0; k < 32; k++) begin
            drive(0, 0, 1, 0, 0);
            n_cmp++;
            if (deq_valid !== 1'b1 || deq_data !== WIDTH'(16 + k)) begin n_fail++; $display("[TB] FAIL wrap_order: got %b/%0d expected 1/%0d", deq_valid, deq_data, 16 + k); end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 5; k++) begin drive(1, $urandom, 0, 0, 0); tick(); end
        for (int c = 0; c < 40; c++) begin
            drive(1, $urandom, 1, 0, 0);
            n_cmp += 3;
            if (count !== 6'd5) begin n_fail++; $display("[TB] FAIL simul_count: got %0d expected 5", count); end
            if (deq_data !== q[0]) begin n_fail++; $display("[TB] FAIL simul_order: got %h expected %h", deq_data, q[0]); end
            if (ram_windex !== 5'(m_w) || ram_windex === ram_rindex) begin n_fail++; $display("[TB] FAIL simul_windex: got %0d expected %0d", ram_windex, m_w); end
            tick();
        end
    endtask

    task automatic test_overflow();
        while (q.size() < DEPTH) begin drive(1, $urandom, 0, 0, 0); tick(); end
        drive(1, 32'h0BAD0BAD, 1, 0, 0);
        n_cmp += 2;
        if (enq_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_enq_ready: got %b expected 0", enq_ready); end
        if (ram_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_wen: got %b expected 0", ram_wen); end
        tick();
        drive(0, 0, 0, 0, 0);
        n_cmp += 2;
        if (count !== 6'd31) begin n_fail++; $display("[TB] FAIL ovf_count: got %0d expected 31", count); end
        if (ovf_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set: got %b expected 1", ovf_err); end
        for (int c = 0; c < 3; c++) begin drive(1, $urandom, 1, 0, 0); tick(); end
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (ovf_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky: got %b expected 1", ovf_err); end
    endtask

    task automatic test_flush();
        while (q.size() > 10) begin drive(0, 0, 1, 0, 0); tick(); end
        drive(1, $urandom, 0, 1, 0);
        n_cmp += 2;
        if (count !== 6'd10) begin n_fail++; $display("[TB] FAIL flush_pre_count: got %0d expected 10", count); end
        if (ram_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_wen: got %b expected 0", ram_wen); end
        tick();
        drive(1, 32'h12345678, 0, 0, 0);
        n_cmp += 4;
        if (count !== 6'd0 || deq_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_empty: got %0d/%b expected 0/0", count, deq_valid); end
        if (ram_rindex !== 5'd0) begin n_fail++; $display("[TB] FAIL flush_rindex: got %0d expected 0", ram_rindex); end
        if (ram_windex !== 5'd0) begin n_fail++; $display("[TB] FAIL flush_windex: got %0d expected 0", ram_windex); end
        if (ovf_err !== m_ovf) begin n_fail++; $display("[TB] FAIL flush_ovf: got %b expected %b", ovf_err, m_ovf); end
        tick();
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (deq_data !== 32'h12345678) begin n_fail++; $display("[TB] FAIL flush_after_data: got %h expected 12345678", deq_data); end
    endtask

    task automatic test_random();
        bit ev, dr, fl, rs;
        for (int c = 0; c < 600; c++) begin
            ev = ($urandom_range(0, 99) < 60);
            dr = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 99) < 2);
            rs = ($urandom_range(0, 199) < 1);
            drive(ev, $urandom, dr, fl, rs);
            n_cmp += 6;
            if (count !== 6'(q.size())) begin n_fail++; $display("[TB] FAIL rand_count: got %0d expected %0d", count, q.size()); end
            if (deq_valid !== (q.size() > 0)) begin n_fail++; $display("[TB] FAIL rand_deq_valid: got %b expected %b", deq_valid, q.size() > 0); end
            if (enq_ready !== (q.size() < DEPTH) || almost_full !== (q.size() >= AFULL)) begin n_fail++; $display("[TB] FAIL rand_flags: got %b%b expected %b%b", enq_ready, almost_full, q.size() < DEPTH, q.size() >= AFULL); end
            if (ovf_err !== m_ovf) begin n_fail++; $display("[TB] FAIL rand_ovf: got %b expected %b", ovf_err, m_ovf); end
            if (ram_wen !== (ev && !fl && q.size() < DEPTH)) begin n_fail++; $display("[TB] FAIL rand_wen: got %b expected %b", ram_wen, ev && !fl && q.size() < DEPTH); end
            if (ram_windex !== 5'(m_w) || ram_rindex !== 5'(m_r)) begin n_fail++; $display("[TB] FAIL rand_index: got %0d/%0d expected %0d/%0d", ram_windex, ram_rindex, m_w, m_r); end
            if (q.size() > 0) begin
                n_cmp++;
                if (deq_data !== q[0]) begin n_fail++; $display("[TB] FAIL rand_data: got %h expected %h", deq_data, q[0]); end
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; m_ovf = 0; m_w = 0; m_r = 0;
        enq_valid = 0; enq_data = 0; deq_ready = 0; flush = 0; RST = 1;
        test_reset();
        test_single();
        test_fill_wrap();
        test_simultaneous();
        test_overflow();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
